// File: rtl/t05_code_serializer_if.sv
// Handshake bundle for t05_code_serializer: frame control, code stream
// in, serial bit stream out, and frame status.
interface t05_code_serializer_if #(
    parameter int CNT_W  = 32,
    parameter int PATH_W = 128,
    parameter int LEN_W  = $clog2(PATH_W + 1)
);
    logic              start;
    logic [CNT_W-1:0]  totChar;
    logic              code_valid;
    logic              code_ready;
    logic [PATH_W-1:0] code;
    logic [LEN_W-1:0]  code_len;
    logic              code_last;
    logic              bit_out;
    logic              bit_valid;
    logic              bit_ready;
    logic              busy;
    logic              done;
    logic [31:0]       bits_sent;

    modport master (
        output start, totChar, code_valid, code, code_len, code_last,
        output bit_ready,
        input  code_ready, bit_out, bit_valid, busy, done, bits_sent
    );

    modport slave (
        input  start, totChar, code_valid, code, code_len, code_last,
        input  bit_ready,
        output code_ready, bit_out, bit_valid, busy, done, bits_sent
    );
endinterface

// File: rtl/t05_code_serializer.sv
// Serializes a CNT_W-bit header then variable-length codes, MSB-first.
// Define T05_SER_PAD_EN to zero-pad each frame to a byte boundary.
module t05_code_serializer #(
    parameter int CNT_W  = 32,
    parameter int PATH_W = 128,
    parameter int LEN_W  = $clog2(PATH_W + 1)
) (
    input logic                  clk,
    input logic                  rst,
    t05_code_serializer_if.slave bus
);
    localparam int HIDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int CIDX_W = (PATH_W > 1) ? $clog2(PATH_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_WAIT_CODE,
        S_SHIFT,
`ifdef T05_SER_PAD_EN
        S_PAD,
`endif
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_hdr;
    logic [PATH_W-1:0] r_code;
    logic [HIDX_W-1:0] r_hidx;
    logic [CIDX_W-1:0] r_cidx;
    logic              r_last;
    logic              r_bit_out;
    logic              r_bit_valid;
    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_bits_sent;

    logic              w_xfer;
    logic [31:0]       w_sent_inc;
    logic [LEN_W-1:0]  w_len;
    logic [CIDX_W-1:0] w_cstart;
    logic [HIDX_W-1:0] w_hidx_dn;
    logic [CIDX_W-1:0] w_cidx_dn;

    assign w_xfer     = r_bit_valid && bus.bit_ready;
    assign w_sent_inc = r_bits_sent + 32'd1;
    // Oversized lengths are clamped so the shift index stays in range
    assign w_len      = (bus.code_len > LEN_W'(PATH_W)) ?
                        LEN_W'(PATH_W) : bus.code_len;
    assign w_cstart   = CIDX_W'(w_len - LEN_W'(1));
    assign w_hidx_dn  = r_hidx - 1'b1;
    assign w_cidx_dn  = r_cidx - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hdr       <= '0;
            r_code      <= '0;
            r_hidx      <= '0;
            r_cidx      <= '0;
            r_last      <= 1'b0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bits_sent <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_hdr       <= bus.totChar;
                        r_hidx      <= HIDX_W'(CNT_W - 1);
                        r_bit_out   <= bus.totChar[CNT_W-1];
                        r_bit_valid <= 1'b1;
                        r_bits_sent <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (w_xfer) begin
                        r_bits_sent <= w_sent_inc;
                        if (r_hidx == '0) begin
                            r_bit_valid <= 1'b0;
                            r_state     <= S_WAIT_CODE;
                        end else begin
                            r_hidx    <= w_hidx_dn;
                            r_bit_out <= r_hdr[w_hidx_dn];
                        end
                    end
                end
                S_WAIT_CODE: begin
                    if (bus.code_valid) begin
                        r_code <= bus.code;
                        r_last <= bus.code_last;
                        if (w_len != '0) begin
                            r_cidx      <= w_cstart;
                            r_bit_out   <= bus.code[w_cstart];
                            r_bit_valid <= 1'b1;
                            r_state     <= S_SHIFT;
                        end else if (bus.code_last) begin
`ifdef T05_SER_PAD_EN
                            if (r_bits_sent[2:0] != 3'd0) begin
                                r_bit_out   <= 1'b0;
                                r_bit_valid <= 1'b1;
                                r_state     <= S_PAD;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
`else
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
`endif
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_xfer) begin
                        r_bits_sent <= w_sent_inc;
                        if (r_cidx == '0) begin
                            r_bit_valid <= 1'b0;
                            if (!r_last) begin
                                r_state <= S_WAIT_CODE;
                            end else begin
`ifdef T05_SER_PAD_EN
                                if (w_sent_inc[2:0] != 3'd0) begin
                                    r_bit_out   <= 1'b0;
                                    r_bit_valid <= 1'b1;
                                    r_state     <= S_PAD;
                                end else begin
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end
`else
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
`endif
                            end
                        end else begin
                            r_cidx    <= w_cidx_dn;
                            r_bit_out <= r_code[w_cidx_dn];
                        end
                    end
                end
`ifdef T05_SER_PAD_EN
                S_PAD: begin
                    if (w_xfer) begin
                        r_bits_sent <= w_sent_inc;
                        if (w_sent_inc[2:0] == 3'd0) begin
                            r_bit_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.code_ready = (r_state == S_WAIT_CODE);
    assign bus.bit_out    = r_bit_out;
    assign bus.bit_valid  = r_bit_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.bits_sent  = r_bits_sent;
endmodule

// File: tb/tb_t05_code_serializer.sv
// Directed bench for t05_code_serializer: frame vector table plus
// hand sequences for header, start-while-busy and mid-frame reset.
module tb_t05_code_serializer;
    logic clk;
    logic rst;
    logic stall_mode;

    int n_vec;
    int n_err;
    int n_done;
    bit q[$];
    logic prev_stall;
    logic prev_bit;

    t05_code_serializer_if #(.CNT_W(32), .PATH_W(128)) bif ();

    t05_code_serializer #(.CNT_W(32), .PATH_W(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [31:0]  tot;
        logic [127:0] c0;
        logic [7:0]   l0;
        logic [127:0] c1;
        logic [7:0]   l1;
        bit           stall;
        int           n;
        logic [127:0] exp;
        logic [31:0]  sent;
        logic [31:0]  sent_pad;
    } vec_t;

    vec_t vecs[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: records transfers, counts done pulses, checks stall holding
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(bif.bit_valid), 32'd1);
                chk("stall_bit", 32'(bif.bit_out), 32'(prev_bit));
            end
            if (bif.bit_valid && bif.bit_ready) q.push_back(bif.bit_out);
            if (bif.done) n_done++;
            prev_stall = bif.bit_valid && !bif.bit_ready;
            prev_bit   = bif.bit_out;
        end
    end

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            bif.bit_ready = stall_mode ? ~bif.bit_ready : 1'b1;
        end
    endtask

    task automatic start_frame(input logic [31:0] tot);
        @(posedge clk);
        #1;
        bif.start   = 1'b1;
        bif.totChar = tot;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
    endtask

    task automatic send_code(input logic [127:0] c, input logic [7:0] l,
                             input logic last);
        bit got;
        bif.code       = c;
        bif.code_len   = l;
        bif.code_last  = last;
        bif.code_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (bif.code_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        bif.code_valid = 1'b0;
        chk("code_accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (bif.done) got = 1'b1;
        end
        chk("done_timeout", 32'(got), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        bit e[$];
        int bad;
        logic [31:0] exp_sent;
        q.delete();
        n_done = 0;
        stall_mode = v.stall;
`ifdef T05_SER_PAD_EN
        exp_sent = v.sent_pad;
`else
        exp_sent = v.sent;
`endif
        start_frame(v.tot);
        send_code(v.c0, v.l0, 1'b0);
        send_code(v.c1, v.l1, 1'b1);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 31; i >= 0; i--) e.push_back(v.tot[i]);
        for (int i = v.n - 1; i >= 0; i--) e.push_back(v.exp[i]);
        for (int i = int'(v.sent); i < int'(exp_sent); i++) e.push_back(1'b0);
        bad = -1;
        for (int i = 0; i < e.size(); i++) begin
            if (bad < 0 && (i >= q.size() || q[i] !== e[i])) bad = i;
        end
        chk({nm, "_nbits"}, 32'(q.size()), 32'(e.size()));
        chk({nm, "_first_bad_bit"}, 32'(bad), 32'hFFFF_FFFF);
        chk({nm, "_bits_sent"}, bif.bits_sent, exp_sent);
        chk({nm, "_done_pulses"}, 32'(n_done), 32'd1);
        chk({nm, "_busy_after"}, 32'(bif.busy), 32'd0);
        stall_mode = 1'b0;
    endtask

    initial begin
        logic [31:0] hv;
        bit got;
        n_vec = 0;
        n_err = 0;
        n_done = 0;
        stall_mode = 1'b0;
        prev_stall = 1'b0;
        prev_bit = 1'b0;
        rst = 1'b1;
        bif.start = 1'b0;
        bif.totChar = '0;
        bif.code_valid = 1'b0;
        bif.code = '0;
        bif.code_len = '0;
        bif.code_last = 1'b0;
        bif.bit_ready = 1'b1;

        vecs[0] = '{32'h8000_0003, 128'b010, 8'd3, 128'b1, 8'd1, 1'b0,
                    4, 128'b0101, 32'd36, 32'd40};
        vecs[1] = '{32'h0000_0000, 128'd0, 8'd0, 128'b00101, 8'd5, 1'b1,
                    5, 128'b00101, 32'd37, 32'd40};
        vecs[2] = '{32'hFFFF_FFFF, 128'b1, 8'd1, 128'd0, 8'd0, 1'b0,
                    1, 128'b1, 32'd33, 32'd40};
        vecs[3] = '{32'h1234_5678, 128'b110, 8'd3, 128'h01, 8'd8, 1'b1,
                    11, 128'h601, 32'd43, 32'd48};
        vecs[4] = '{32'hA5A5_A5A5, 128'd0, 8'd2, 128'hF5, 8'd3, 1'b0,
                    5, 128'b00101, 32'd37, 32'd40};
        vecs[5] = '{32'h0000_00FF, 128'b01, 8'd2, 128'b1, 8'd1, 1'b0,
                    3, 128'b011, 32'd35, 32'd40};
        vecs[6] = '{32'h0000_0000, 128'd0, 8'd0, {128{1'b1}}, 8'd128,
                    1'b0, 128, {128{1'b1}}, 32'd160, 32'd160};
        vecs[7] = '{32'h8000_0001, {128{1'b1}}, 8'd200, 128'd0, 8'd0,
                    1'b1, 128, {128{1'b1}}, 32'd160, 32'd160};
        vecs[8] = '{32'h0F0F_0F0F, 128'd1, 8'd128, 128'd0, 8'd0, 1'b0,
                    128, 128'd1, 32'd160, 32'd160};

        fork
            ready_driver();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_bit_valid", 32'(bif.bit_valid), 32'd0);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_done", 32'(bif.done), 32'd0);
        chk("rst_bits_sent", bif.bits_sent, 32'd0);
        chk("rst_code_ready", 32'(bif.code_ready), 32'd0);

        // Header alone, then start pulses while busy must be ignored
        q.delete();
        n_done = 0;
        start_frame(32'h8000_0003);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bif.code_ready) got = 1'b1;
        end
        chk("hdr_wait_timeout", 32'(got), 32'd1);
        chk("hdr_bits_sent", bif.bits_sent, 32'd32);
        chk("hdr_nbits", 32'(q.size()), 32'd32);
        hv = '0;
        for (int i = 0; i < q.size() && i < 32; i++) hv = {hv[30:0], q[i]};
        chk("hdr_value", hv, 32'h8000_0003);
        @(posedge clk);
        #1;
        bif.start = 1'b1;
        bif.totChar = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        bif.start = 1'b0;
        chk("busy_start_code_ready", 32'(bif.code_ready), 32'd1);
        chk("busy_start_bits_sent", bif.bits_sent, 32'd32);
        chk("busy_start_bit_valid", 32'(bif.bit_valid), 32'd0);
        send_code(128'b1, 8'd1, 1'b1);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
`ifdef T05_SER_PAD_EN
        chk("hdr_frame_bits_sent", bif.bits_sent, 32'd40);
`else
        chk("hdr_frame_bits_sent", bif.bits_sent, 32'd33);
`endif
        chk("hdr_frame_done_pulses", 32'(n_done), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a long code: abort, no done pulse
        q.delete();
        n_done = 0;
        start_frame(32'h0000_0000);
        send_code({128{1'b1}}, 8'd128, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (q.size() >= 40) got = 1'b1;
        end
        chk("midrst_wait_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_bit_valid", 32'(bif.bit_valid), 32'd0);
        chk("midrst_busy", 32'(bif.busy), 32'd0);
        chk("midrst_done", 32'(bif.done), 32'd0);
        chk("midrst_bits_sent", bif.bits_sent, 32'd0);
        chk("midrst_code_ready", 32'(bif.code_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(n_done), 32'd0);
        chk("midrst_idle_valid", 32'(bif.bit_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
